// File: rtl/dbus_pkg.sv
// Shared types and widths for the dBus SRAM slave: controller state encoding and bus lane geometry.
package dbus_pkg;

    localparam int DBUS_WORD_W = 32;
    localparam int DBUS_BYTE_W = 8;
    localparam int DBUS_BE_W   = DBUS_WORD_W / DBUS_BYTE_W;
    localparam int DBUS_CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dbus_state_e;

endpackage

// File: rtl/dbus_sram_array.sv
// Word-organised single-port SRAM: per-byte-lane synchronous write, combinational read of the applied index.
module dbus_sram_array
    import dbus_pkg::*;
#(
    parameter int DEPTH_WORDS = 4096,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic                   clk,
    input  logic [AW-1:0]          idx,
    input  logic                   we,
    input  logic [DBUS_BE_W-1:0]   be,
    input  logic [DBUS_WORD_W-1:0] wdata,
    output logic [DBUS_WORD_W-1:0] rdata
);

    logic [DBUS_WORD_W-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < DBUS_BE_W; i++) begin
                if (be[i]) begin
                    mem[idx][i*DBUS_BYTE_W +: DBUS_BYTE_W] <= wdata[i*DBUS_BYTE_W +: DBUS_BYTE_W];
                end
            end
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/dbus_sram_ctrl.sv
// dBus data-memory slave: accepts one load/store at a time, waits WAIT_STATES cycles, then returns a
// single-cycle response, flagging out-of-range or misaligned addresses as bus errors.
module dbus_sram_ctrl
    import dbus_pkg::*;
#(
    parameter int          DEPTH_WORDS = 4096,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_STATES = 1
) (
    input  logic                   clk,
    input  logic                   rstf,
    input  logic                   dBus_cmd_valid,
    output logic                   dBus_cmd_ready,
    input  logic [DBUS_WORD_W-1:0] dBus_cmd_payload_addr,
    input  logic [DBUS_WORD_W-1:0] dBus_cmd_payload_data,
    input  logic [DBUS_BE_W-1:0]   dBus_cmd_payload_size,
    input  logic                   dBus_cmd_payload_wr,
    output logic [DBUS_WORD_W-1:0] dBus_rsp_data,
    output logic                   dBus_rsp_valid,
    output logic                   dBus_rsp_error
);

    localparam int                    AW      = $clog2(DEPTH_WORDS);
    localparam logic [32:0]           SPAN    = 33'(DEPTH_WORDS) << 2;
    localparam logic [DBUS_CNT_W-1:0] WS_LOAD = DBUS_CNT_W'(WAIT_STATES);

    dbus_state_e            state_q, state_d;
    logic [DBUS_CNT_W-1:0]  cnt_q, cnt_d;
    logic [AW-1:0]          idx_q;
    logic [DBUS_WORD_W-1:0] data_q;
    logic [DBUS_BE_W-1:0]   mask_q;
    logic                   wr_q;
    logic                   err_q;

    logic [32:0]            offset;
    logic                   cmd_err;
    logic                   accept;
    logic                   resp;
    logic                   mem_we;
    logic [DBUS_WORD_W-1:0] mem_rdata;

    // Handshake: a command transfers on a rising edge where valid && ready. Ready is a function of
    // registered state (and reset) only, so the master may hold valid high without creating a loop;
    // valid seen while ready is low is simply ignored.
    assign dBus_cmd_ready = (state_q == IDLE) && !rstf;
    assign accept         = dBus_cmd_valid && dBus_cmd_ready;

    // 33-bit offset: an address below BASE_ADDR wraps to a huge value and fails the span test too.
    assign offset  = {1'b0, dBus_cmd_payload_addr} - {1'b0, BASE_ADDR};
    assign cmd_err = (offset >= SPAN) || (dBus_cmd_payload_addr[1:0] != 2'b00);

    always_ff @(posedge clk or posedge rstf) begin
        if (rstf) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            mask_q  <= '0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                idx_q  <= offset[AW+1:2];
                data_q <= dBus_cmd_payload_data;
                mask_q <= dBus_cmd_payload_size;
                wr_q   <= dBus_cmd_payload_wr;
                err_q  <= cmd_err;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    cnt_d   = WS_LOAD;
                    state_d = (WAIT_STATES > 0) ? WAIT : RESP;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == 1) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Writes commit at the end of RESP, so a following read can never overtake them.
    assign resp           = (state_q == RESP);
    assign mem_we         = resp && wr_q && !err_q;
    assign dBus_rsp_valid = resp;
    assign dBus_rsp_error = resp && err_q;
    assign dBus_rsp_data  = (resp && !wr_q && !err_q) ? mem_rdata : '0;

    dbus_sram_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .clk   (clk),
        .idx   (idx_q),
        .we    (mem_we),
        .be    (mask_q),
        .wdata (data_q),
        .rdata (mem_rdata)
    );

endmodule
